// File: rtl/burst_adr_gen.sv
// Wishbone burst address generator: linear / wrap-4/8/16 stepping, one step per accepted inc, registered outputs.
// init -> LOAD (1 cycle read lead) -> BURST/DONE; BURST_ADR_GEN_WRAP16_EN makes bte=11 a true wrap-16.
module burst_adr_gen #(
    parameter int ADR_WIDTH      = 24,
    parameter int LIN_BOUND_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADR_WIDTH-1:0] adr_i,
    input  logic [2:0]           cti_i,
    input  logic [1:0]           bte_i,
    input  logic                 init,
    input  logic                 inc,
    output logic [ADR_WIDTH-1:0] adr_o,
    output logic                 done,
    output logic                 last,
    output logic                 busy
);

    localparam int CW = LIN_BOUND_LOG2 + 1;
    localparam logic [CW-1:0] LIN_SPAN = {1'b1, {LIN_BOUND_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, BURST, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADR_WIDTH-1:0]   adr_q, adr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic [ADR_WIDTH-1:0]   sh_adr_q, sh_adr_d;
    logic [2:0]             sh_cti_q, sh_cti_d;
    logic [1:0]             sh_bte_q, sh_bte_d;

    logic [CW-1:0]          lin_cnt;
    logic [CW-1:0]          load_cnt;
    logic [ADR_WIDTH-1:0]   wrap_mask;
    logic [ADR_WIDTH-1:0]   adr_inc;
    logic [ADR_WIDTH-1:0]   adr_step;

    // Beats remaining until the linear boundary, including the start beat.
    assign lin_cnt = LIN_SPAN - {1'b0, sh_adr_q[LIN_BOUND_LOG2-1:0]};

    always_comb begin
        load_cnt = lin_cnt;
        case (sh_bte_q)
            2'b01:   load_cnt = CW'(4);
            2'b10:   load_cnt = CW'(8);
            2'b11:   load_cnt = CW'(16);
            default: load_cnt = lin_cnt;
        endcase
    end

    // Bits covered by the mask increment; bits outside it are held.
    always_comb begin
        wrap_mask = '1;
        case (sh_bte_q)
            2'b01:   wrap_mask = ADR_WIDTH'(3);
            2'b10:   wrap_mask = ADR_WIDTH'(7);
`ifdef BURST_ADR_GEN_WRAP16_EN
            2'b11:   wrap_mask = ADR_WIDTH'(15);
`else
            2'b11:   wrap_mask = '1;
`endif
            default: wrap_mask = '1;
        endcase
    end

    assign adr_inc  = adr_q + ADR_WIDTH'(1);
    assign adr_step = (adr_q & ~wrap_mask) | (adr_inc & wrap_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        last_d   = last_q;
        sh_adr_d = sh_adr_q;
        sh_cti_d = sh_cti_q;
        sh_bte_d = sh_bte_q;

        if (init) begin
            sh_adr_d = adr_i;
            sh_cti_d = cti_i;
            sh_bte_d = bte_i;
            state_d  = LOAD;
            done_d   = 1'b0;
            last_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    adr_d = sh_adr_q;
                    cnt_d = load_cnt;
                    if (sh_cti_q == 3'b000 || sh_cti_q == 3'b111) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        last_d  = 1'b0;
                    end else begin
                        state_d = BURST;
                        last_d  = (load_cnt == CW'(1));
                    end
                end
                BURST: begin
                    if (inc) begin
                        adr_d = adr_step;
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            last_d  = 1'b0;
                        end else begin
                            last_d  = (cnt_q == CW'(2));
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d = (state_d == LOAD) || (state_d == BURST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            sh_adr_q <= '0;
            sh_cti_q <= '0;
            sh_bte_q <= '0;
        end else begin
            adr_q    <= adr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            sh_adr_q <= sh_adr_d;
            sh_cti_q <= sh_cti_d;
            sh_bte_q <= sh_bte_d;
        end
    end

    assign adr_o = adr_q;
    assign done  = done_q;
    assign last  = last_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_burst_adr_gen.sv
// Directed bench for burst_adr_gen with ADR_WIDTH=8, LIN_BOUND_LOG2=4.
module tb_burst_adr_gen;

    logic       clk;
    logic       rst;
    logic [7:0] adr_i;
    logic [2:0] cti_i;
    logic [1:0] bte_i;
    logic       init;
    logic       inc;
    logic [7:0] adr_o;
    logic       done;
    logic       last;
    logic       busy;

    int checks;
    int errors;

    burst_adr_gen #(.ADR_WIDTH(8), .LIN_BOUND_LOG2(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .adr_i (adr_i),
        .cti_i (cti_i),
        .bte_i (bte_i),
        .init  (init),
        .inc   (inc),
        .adr_o (adr_o),
        .done  (done),
        .last  (last),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after edge k (init sampled).
    task automatic start(input logic [7:0] a, input logic [2:0] c, input logic [1:0] b);
        adr_i = a;
        cti_i = c;
        bte_i = b;
        init  = 1'b1;
        tick();
        init  = 1'b0;
    endtask

    task automatic step();
        inc = 1'b1;
        tick();
        inc = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (adr_o !== 8'h00) begin errors++; $display("FAIL reset_adr got %h want 00", adr_o); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", last); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        step();
        checks++;
        if (adr_o !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_inc adr %h busy %b want 00 0", adr_o, busy);
        end
    endtask

    task automatic test_wrap4();
        logic [7:0] exp_adr  [4] = '{8'h37, 8'h34, 8'h35, 8'h36};
        logic       exp_last [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_done [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        start(8'h36, 3'b010, 2'b01);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL wrap4_busy_k got %b want 1", busy); end
        tick();
        checks++;
        if (adr_o !== 8'h36 || done !== 1'b0 || last !== 1'b0) begin
            errors++; $display("FAIL wrap4_k1 adr %h done %b last %b want 36 0 0", adr_o, done, last);
        end
        cti_i = 3'b111;
        bte_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (adr_o !== exp_adr[i] || last !== exp_last[i] || done !== exp_done[i]) begin
                errors++;
                $display("FAIL wrap4_beat%0d adr %h last %b done %b want %h %b %b",
                         i, adr_o, last, done, exp_adr[i], exp_last[i], exp_done[i]);
            end
        end
        step();
        checks++;
        if (adr_o !== 8'h36 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL wrap4_extra adr %h done %b busy %b want 36 1 0", adr_o, done, busy);
        end
    endtask

    task automatic test_linear();
        logic [7:0] exp_adr  [3] = '{8'h1E, 8'h1F, 8'h20};
        logic       exp_last [3] = '{1'b0, 1'b1, 1'b0};
        logic       exp_done [3] = '{1'b0, 1'b0, 1'b1};
        start(8'h1D, 3'b010, 2'b00);
        tick();
        checks++;
        if (adr_o !== 8'h1D || busy !== 1'b1) begin
            errors++; $display("FAIL lin_k1 adr %h busy %b want 1D 1", adr_o, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (adr_o !== exp_adr[i] || last !== exp_last[i] || done !== exp_done[i]) begin
                errors++;
                $display("FAIL lin_beat%0d adr %h last %b done %b want %h %b %b",
                         i, adr_o, last, done, exp_adr[i], exp_last[i], exp_done[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL lin_busy got %b want 0", busy); end
    endtask

    task automatic test_classic(input logic [2:0] c);
        start(8'hA5, c, 2'b10);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL cls%0d_k busy %b done %b want 1 0", c, busy, done);
        end
        tick();
        checks++;
        if (adr_o !== 8'hA5 || done !== 1'b1 || busy !== 1'b0 || last !== 1'b0) begin
            errors++;
            $display("FAIL cls%0d_k1 adr %h done %b busy %b last %b want A5 1 0 0", c, adr_o, done, busy, last);
        end
        step();
        step();
        checks++;
        if (adr_o !== 8'hA5 || done !== 1'b1) begin
            errors++; $display("FAIL cls%0d_inc adr %h done %b want A5 1", c, adr_o, done);
        end
    endtask

    task automatic test_bte11();
        logic [7:0] exp_a;
        exp_a = 8'h4E;
        start(8'h4E, 3'b010, 2'b11);
        tick();
        for (int i = 0; i < 16; i++) begin
`ifdef BURST_ADR_GEN_WRAP16_EN
            exp_a = {exp_a[7:4], exp_a[3:0] + 4'd1};
`else
            exp_a = exp_a + 8'd1;
`endif
            step();
            checks++;
            if (adr_o !== exp_a || last !== (i == 14) || done !== (i == 15)) begin
                errors++;
                $display("FAIL b11_beat%0d adr %h last %b done %b want %h %b %b",
                         i, adr_o, last, done, exp_a, (i == 14), (i == 15));
            end
        end
        checks++;
`ifdef BURST_ADR_GEN_WRAP16_EN
        if (adr_o !== 8'h4E) begin errors++; $display("FAIL b11_end got %h want 4E", adr_o); end
`else
        if (adr_o !== 8'h5E) begin errors++; $display("FAIL b11_end got %h want 5E", adr_o); end
`endif
    endtask

    task automatic test_restart();
        start(8'h10, 3'b010, 2'b10);
        tick();
        step();
        step();
        checks++;
        if (adr_o !== 8'h12) begin errors++; $display("FAIL rs_pre got %h want 12", adr_o); end
        adr_i = 8'h80;
        init  = 1'b1;
        inc   = 1'b1;
        tick();
        init  = 1'b0;
        checks++;
        if (adr_o !== 8'h12 || busy !== 1'b1 || done !== 1'b0 || last !== 1'b0) begin
            errors++;
            $display("FAIL rs_k adr %h busy %b done %b last %b want 12 1 0 0", adr_o, busy, done, last);
        end
        tick();
        inc = 1'b0;
        checks++;
        if (adr_o !== 8'h80 || done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL rs_k1 adr %h done %b busy %b want 80 0 1", adr_o, done, busy);
        end
        step();
        checks++;
        if (adr_o !== 8'h81) begin errors++; $display("FAIL rs_step got %h want 81", adr_o); end
    endtask

    task automatic test_reset_mid();
        inc = 1'b1;
        #2;
        rst = 1'b1;
        #2;
        checks++;
        if (adr_o !== 8'h00 || done !== 1'b0 || last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid adr %h done %b last %b busy %b want 00 0 0 0", adr_o, done, last, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        inc = 1'b0;
        checks++;
        if (adr_o !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_idle adr %h busy %b done %b want 00 0 0", adr_o, busy, done);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        init   = 1'b0;
        inc    = 1'b0;
        adr_i  = 8'h00;
        cti_i  = 3'b000;
        bte_i  = 2'b00;
        tick();
        tick();
        test_reset();
        test_wrap4();
        test_linear();
        test_classic(3'b000);
        test_classic(3'b111);
        test_bte11();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_adr_gen.md
# burst_adr_gen

Parametrised Wishbone burst address generator for the versatile memory controller's port side; the next generation of the 4-bit burst incrementer. Captures a burst's start address, cycle type (CTI) and burst type (BTE), then steps the address once per accepted beat with linear or wrap-4/8/16 arithmetic. It flags the final beat and burst completion, and supports restart mid-burst. Sits between the Wishbone slave front-end and the SDRAM/FIFO address path.

## Interface
- ADR_WIDTH, 24, address width in words; must be >= LIN_BOUND_LOG2.
- LIN_BOUND_LOG2, 4, linear bursts terminate at a 2^LIN_BOUND_LOG2-word boundary; must be >= 4.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- adr_i  in  ADR_WIDTH  burst start address; sampled only when init=1.
- cti_i  in  3  Wishbone CTI; sampled only when init=1.
- bte_i  in  2  Wishbone BTE; sampled only when init=1.
- init  in  1  start or restart a burst.
- inc  in  1  advance one beat.
- adr_o  out  ADR_WIDTH  current beat address.
- done  out  1  burst complete.
- last  out  1  current adr_o is the final beat.
- busy  out  1  in LOAD or BURST.

## Operation
- States: IDLE, LOAD, BURST, DONE.
- Reset, any state: state=IDLE; adr_o=0, done=0, last=0, busy=0; shadow registers and beat counter cleared.
- init=1 in any state:
  - capture adr_i/cti_i/bte_i into shadow registers;
  - go to LOAD; clear done and last.
  - init takes priority over a simultaneous inc; that inc is dropped.
- LOAD (exactly one cycle; gives the memory one cycle of read lead):
  - adr_o <= shadow address.
  - Load beat counter (width LIN_BOUND_LOG2+1): bte 01 -> 4; bte 10 -> 8; bte 11 -> 16; bte 00 -> 2^LIN_BOUND_LOG2 - (adr mod 2^LIN_BOUND_LOG2).
  - If CTI = 000 (classic) or 111 (end-of-burst), regardless of BTE: go to DONE with done=1, last=0.
  - Otherwise go to BURST, last = (count==1).
- BURST, inc=1:
  - Step adr_o per mode.
  - Decrement counter; last <= (new count == 1).
  - When the count reaches 0: go to DONE, done=1, last=0.
- Address arithmetic:
  - Linear: adr_o+1, modulo 2^ADR_WIDTH.
  - Wrap-N: low log2(N) bits increment modulo N; upper bits held.
- inc in IDLE, LOAD or DONE: ignored; adr_o holds.
- DONE: done and adr_o held until the next init.
- IDLE exits only via init.
- CTI/BTE changes after init are ignored until the next init.

## Timing
- init high at edge k -> busy=1 after k.
- Edge k+1: adr_o = start address; done valid; state = BURST or DONE.
- First inc is accepted at edge k+2 at the earliest.
- One address step per accepted inc, visible the cycle after the edge; zero-bubble back-to-back incs.
- done rises on the same edge as the final step; busy falls on that edge.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- Macro: BURST_ADR_GEN_WRAP16_EN.
- Defined: bte=11 is wrap-16 (low 4 bits wrap), 16 beats.
- Undefined: bte=11 uses linear increment with a fixed 16-beat count (previous-generation behaviour).
- All other modes are unaffected.

## Test plan
All scenarios use ADR_WIDTH=8, LIN_BOUND_LOG2=4.
- Wrap-4: init with adr_i=0x36, cti=010, bte=01, then 4 incs -> adr_o 36,37,34,35,36. last=1 only while adr_o=0x35. done=1 with adr_o=0x36; a 5th inc leaves 0x36.
- Linear to boundary: adr_i=0x1D, cti=010, bte=00, then 3 incs -> adr_o 1D,1E,1F,20. done after the 3rd inc; busy=0.
- Classic/EOB: cti=000, bte=10, adr_i=0xA5 -> edge k+1 gives adr_o=A5, done=1, busy high for one cycle; incs ignored. Repeat with cti=111 -> same result.
- bte=11 at adr_i=0x4E, 16 incs:
  - macro defined: 4F,40,...,4E, done;
  - macro undefined: ends at 0x5E, done.
- Restart and priority:
  - wrap-8 at 0x10, 2 incs, then init+inc together with adr_i=0x80 -> inc dropped; adr_o=0x80 at k+1; done=0.
  - Assert rst mid-burst -> adr_o=0, done=last=busy=0 immediately; state IDLE.
